// File: rtl/pwm_state_scheduler_if.sv
// Requester-side bundle of the PWM state scheduler: requests, commands,
// acknowledges and the encoded output line.
interface pwm_state_scheduler_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] cmd;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   grant;
    logic [1:0]         cur_state;
    logic               pwm;
    logic               frame_start;

    // Requesters and observers
    modport master (
        output req, cmd,
        input  ack, grant, cur_state, pwm, frame_start
    );

    // Scheduler
    modport slave (
        input  req, cmd,
        output ack, grant, cur_state, pwm, frame_start
    );
endinterface

// File: rtl/pwm_state_scheduler.sv
// pwm_state_scheduler: round-robin arbiter between N_REQ motor-state
// requesters. The granted 2-bit state is encoded as a pulse width inside a
// fixed FRAME-clock frame and held for HOLD_FRAMES frames before re-arbitration.
// Optional feature macro: PWM_SAFE_GAP_EN inserts one OPEN frame whenever the
// state changes between DRIVE and BRAKE/SHORT.
module pwm_state_scheduler #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned FRAME       = 1024,
    parameter int unsigned W_BRAKE     = 150,
    parameter int unsigned W_SHORT     = 358,
    parameter int unsigned W_OPEN      = 460,
    parameter int unsigned W_DRIVE     = 768,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pwm_state_scheduler_if.slave bus
);
    localparam int unsigned CNT_W   = $clog2(FRAME);
    localparam int unsigned PTR_W   = $clog2(N_REQ);
    localparam int unsigned DWELL_W = 4;

    localparam logic [1:0] ST_BRAKE = 2'b00;
    localparam logic [1:0] ST_SHORT = 2'b01;
    localparam logic [1:0] ST_OPEN  = 2'b10;
    localparam logic [1:0] ST_DRIVE = 2'b11;

    typedef enum logic {
        S_RUN = 1'b0,
        S_GAP = 1'b1
    } fsm_t;

    fsm_t               r_fsm;
    fsm_t               w_fsm_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_state;
    logic [1:0]         r_pend;
    logic [DWELL_W-1:0] r_dwell;
    logic [PTR_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   r_grant;
    logic [1:0]         r_cur_state;
    logic               r_pwm;
    logic               r_frame_start;

    logic               w_last;
    logic               w_any;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_ptr_inc;
    logic [N_REQ-1:0]   w_onehot;
    logic [1:0]         w_cmd_arr [N_REQ];
    logic [1:0]         w_cmd;
    logic               w_need_gap;

    logic [1:0]         w_state_nxt;
    logic [1:0]         w_pend_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [N_REQ-1:0]   w_ack_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;

    function automatic logic [CNT_W-1:0] width_of(input logic [1:0] s);
        case (s)
            ST_BRAKE: width_of = CNT_W'(W_BRAKE);
            ST_SHORT: width_of = CNT_W'(W_SHORT);
            ST_OPEN:  width_of = CNT_W'(W_OPEN);
            default:  width_of = CNT_W'(W_DRIVE);
        endcase
    endfunction

    // Unpack the per-requester command fields
    for (genvar g = 0; g < N_REQ; g++) begin : g_cmd
        assign w_cmd_arr[g] = bus.cmd[2*g +: 2];
    end

    assign w_last = (r_cnt == CNT_W'(FRAME - 1));

    // Round-robin search upward from the pointer; lowest offset wins
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = PTR_W'((32'(r_ptr) + 32'(k)) % N_REQ);
            if (bus.req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_cmd     = w_cmd_arr[w_win];
    assign w_onehot  = N_REQ'(1) << w_win;
    assign w_ptr_inc = (32'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;

`ifdef PWM_SAFE_GAP_EN
    // DRIVE <-> BRAKE/SHORT must pass through an OPEN frame
    assign w_need_gap = ((r_state == ST_DRIVE) && ((w_cmd == ST_BRAKE) || (w_cmd == ST_SHORT))) ||
                        (((r_state == ST_BRAKE) || (r_state == ST_SHORT)) && (w_cmd == ST_DRIVE));
`else
    assign w_need_gap = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm <= S_RUN;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM next state: a gap frame is entered at a granting decision and lasts one frame
    always_comb begin
        w_fsm_nxt = r_fsm;
        if (w_last) begin
            case (r_fsm)
                S_RUN: if ((r_dwell == '0) && w_any && w_need_gap) w_fsm_nxt = S_GAP;
                S_GAP: w_fsm_nxt = S_RUN;
                default: w_fsm_nxt = S_RUN;
            endcase
        end
    end

    // FSM outputs: decision-point updates of state, dwell, pointer, grant and ack
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_dwell_nxt = r_dwell;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_ack_nxt   = '0;
        if (w_last) begin
            if (r_fsm == S_GAP) begin
                w_state_nxt = r_pend;
                w_dwell_nxt = DWELL_W'(HOLD_FRAMES - 1);
            end else if (r_dwell != '0) begin
                w_dwell_nxt = r_dwell - 1'b1;
            end else if (w_any) begin
                w_ack_nxt   = w_onehot;
                w_grant_nxt = w_onehot;
                w_ptr_nxt   = w_ptr_inc;
                w_pend_nxt  = w_cmd;
                w_dwell_nxt = DWELL_W'(HOLD_FRAMES - 1);
                w_state_nxt = w_need_gap ? ST_OPEN : w_cmd;
            end else begin
                w_grant_nxt = '0;
            end
        end
    end

    // Frame counter, arbitration state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_state       <= ST_BRAKE;
            r_pend        <= ST_BRAKE;
            r_dwell       <= '0;
            r_ptr         <= '0;
            r_ack         <= '0;
            r_grant       <= '0;
            r_cur_state   <= ST_BRAKE;
            r_pwm         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_last ? '0 : r_cnt + 1'b1;
            r_state       <= w_state_nxt;
            r_pend        <= w_pend_nxt;
            r_dwell       <= w_dwell_nxt;
            r_ptr         <= w_ptr_nxt;
            r_ack         <= w_ack_nxt;
            r_grant       <= w_grant_nxt;
            r_frame_start <= (r_cnt == '0);
            r_pwm         <= (r_cnt < width_of(r_state));
            if (r_cnt == '0) begin
                r_cur_state <= r_state;
            end
        end
    end

    assign bus.ack         = r_ack;
    assign bus.grant       = r_grant;
    assign bus.cur_state   = r_cur_state;
    assign bus.pwm         = r_pwm;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_pwm_state_scheduler.sv
// Frame-level directed bench for pwm_state_scheduler: each table row drives
// req/cmd for one frame and checks width, state, grant and ack of that frame.
module tb_pwm_state_scheduler;
    localparam int FRAME = 1024;

    typedef struct {
        logic [1:0] req;
        logic [3:0] cmd;
        int         w;
        logic [1:0] cs;
        logic [1:0] gnt;
        logic [1:0] ack;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t vecs[$];

    int         f_w;
    logic [1:0] f_cs;
    logic [1:0] f_gnt;
    logic [1:0] f_ak;
    bit         f_ok;

    pwm_state_scheduler_if #(.N_REQ(2)) bus ();

    pwm_state_scheduler #(.N_REQ(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic void add(input logic [1:0] rq, input logic [3:0] cm, input int w,
                                input logic [1:0] cs, input logic [1:0] g, input logic [1:0] a);
        vec_t v;
        v.req = rq; v.cmd = cm; v.w = w; v.cs = cs; v.gnt = g; v.ack = a;
        vecs.push_back(v);
    endfunction

    // Measure one frame; entered and left on a negedge where frame_start=1
    task automatic run_frame(output int w, output logic [1:0] cs, output logic [1:0] gnt,
                             output logic [1:0] ak, output bit ok);
        w   = 0;
        ok  = 1'b1;
        ak  = '0;
        gnt = '0;
        cs  = bus.cur_state;
        for (int c = 0; c < FRAME; c++) begin
            if ((c > 0) && bus.frame_start) ok = 1'b0;
            if (bus.pwm) begin
                if (c != w) ok = 1'b0;
                w++;
            end
            if ((bus.ack != '0) && (c != FRAME - 1)) ok = 1'b0;
            if (c == FRAME / 2) gnt = bus.grant;
            ak = ak | bus.ack;
            @(negedge clk);
        end
        if (!bus.frame_start) ok = 1'b0;
    endtask

    // Run frames until the wanted ack is seen, bounded
    task automatic wait_ack(input logic [1:0] want, input string name);
        logic [1:0] last;
        last = '0;
        for (int k = 0; k < 10; k++) begin
            run_frame(f_w, f_cs, f_gnt, f_ak, f_ok);
            last = f_ak;
            if (f_ak == want) break;
        end
        check(name, last, want);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        bus.req   = '0;
        bus.cmd   = '0;

`ifdef PWM_SAFE_GAP_EN
        add(2'b00, 4'b0000, 150, 2'b00, 2'b00, 2'b00);
        add(2'b01, 4'b0011, 150, 2'b00, 2'b00, 2'b01);
        add(2'b00, 4'b0000, 460, 2'b10, 2'b01, 2'b00);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b01, 2'b00);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b01, 2'b00);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b01, 2'b00);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b01, 2'b00);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b00, 2'b00);
        add(2'b11, 4'b0110, 768, 2'b11, 2'b00, 2'b10);
        add(2'b11, 4'b0110, 460, 2'b10, 2'b10, 2'b00);
        add(2'b11, 4'b0110, 358, 2'b01, 2'b10, 2'b00);
        add(2'b11, 4'b0110, 358, 2'b01, 2'b10, 2'b00);
        add(2'b11, 4'b0110, 358, 2'b01, 2'b10, 2'b00);
        add(2'b11, 4'b0110, 358, 2'b01, 2'b10, 2'b01);
        add(2'b11, 4'b0110, 460, 2'b10, 2'b01, 2'b00);
        add(2'b11, 4'b0110, 460, 2'b10, 2'b01, 2'b00);
        add(2'b11, 4'b0110, 460, 2'b10, 2'b01, 2'b00);
        add(2'b11, 4'b0110, 460, 2'b10, 2'b01, 2'b10);
        add(2'b00, 4'b0110, 358, 2'b01, 2'b10, 2'b00);
`else
        add(2'b00, 4'b0000, 150, 2'b00, 2'b00, 2'b00);
        add(2'b01, 4'b0011, 150, 2'b00, 2'b00, 2'b01);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b01, 2'b00);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b01, 2'b00);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b01, 2'b00);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b01, 2'b00);
        add(2'b00, 4'b0000, 768, 2'b11, 2'b00, 2'b00);
        add(2'b11, 4'b0110, 768, 2'b11, 2'b00, 2'b10);
        add(2'b11, 4'b0110, 358, 2'b01, 2'b10, 2'b00);
        add(2'b11, 4'b0110, 358, 2'b01, 2'b10, 2'b00);
        add(2'b11, 4'b0110, 358, 2'b01, 2'b10, 2'b00);
        add(2'b11, 4'b0110, 358, 2'b01, 2'b10, 2'b01);
        add(2'b11, 4'b0110, 460, 2'b10, 2'b01, 2'b00);
        add(2'b11, 4'b0110, 460, 2'b10, 2'b01, 2'b00);
        add(2'b11, 4'b0110, 460, 2'b10, 2'b01, 2'b00);
        add(2'b11, 4'b0110, 460, 2'b10, 2'b01, 2'b10);
        add(2'b00, 4'b0110, 358, 2'b01, 2'b10, 2'b00);
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pwm", bus.pwm, 0);
        check("rst_fs", bus.frame_start, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_cs", bus.cur_state, 0);
        reset = 1'b1;
        @(negedge clk);
        check("first_fs", bus.frame_start, 1);
        check("first_pwm", bus.pwm, 1);

        // Table-driven frames
        for (int i = 0; i < vecs.size(); i++) begin
            bus.req = vecs[i].req;
            bus.cmd = vecs[i].cmd;
            run_frame(f_w, f_cs, f_gnt, f_ak, f_ok);
            check($sformatf("row%0d_width", i), f_w, vecs[i].w);
            check($sformatf("row%0d_state", i), f_cs, vecs[i].cs);
            check($sformatf("row%0d_grant", i), f_gnt, vecs[i].gnt);
            check($sformatf("row%0d_ack", i), f_ak, vecs[i].ack);
            check($sformatf("row%0d_shape", i), f_ok, 1);
        end

        // Reach a DRIVE frame, then pulse reset mid-frame
        bus.req = 2'b01;
        bus.cmd = 4'b0011;
        wait_ack(2'b01, "seqa_ack");
        bus.req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            run_frame(f_w, f_cs, f_gnt, f_ak, f_ok);
            if (f_cs == 2'b11) break;
        end
        check("seqa_drive_w", f_w, 768);
        repeat (500) @(negedge clk);
        check("seqa_pwm_mid", bus.pwm, 1);
        reset = 1'b0;
        #1;
        check("seqa_rst_pwm", bus.pwm, 0);
        check("seqa_rst_grant", bus.grant, 0);
        check("seqa_rst_cs", bus.cur_state, 0);
        check("seqa_rst_fs", bus.frame_start, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("seqa_rel_fs", bus.frame_start, 1);
        bus.req = 2'b11;
        bus.cmd = 4'b0110;
        run_frame(f_w, f_cs, f_gnt, f_ak, f_ok);
        check("seqa_rel_width", f_w, 150);
        check("seqa_rel_state", f_cs, 0);
        check("seqa_ptr_ack", f_ak, 2'b01);
        check("seqa_rel_shape", f_ok, 1);
        bus.req = 2'b00;

        // DRIVE -> BRAKE, with a competing DRIVE request during the dwell
        bus.req = 2'b01;
        bus.cmd = 4'b0011;
        wait_ack(2'b01, "seqb_ack_drive");
        bus.req = 2'b10;
        wait_ack(2'b10, "seqb_ack_brake");
        bus.req = 2'b01;
`ifdef PWM_SAFE_GAP_EN
        run_frame(f_w, f_cs, f_gnt, f_ak, f_ok);
        check("seqb_gap_width", f_w, 460);
        check("seqb_gap_state", f_cs, 2'b10);
        check("seqb_gap_ack", f_ak, 0);
`endif
        for (int k = 0; k < 4; k++) begin
            run_frame(f_w, f_cs, f_gnt, f_ak, f_ok);
            check($sformatf("seqb_brake%0d_width", k), f_w, 150);
            check($sformatf("seqb_brake%0d_state", k), f_cs, 0);
            check($sformatf("seqb_brake%0d_grant", k), f_gnt, 2'b10);
            check($sformatf("seqb_brake%0d_ack", k), f_ak, (k == 3) ? 2'b01 : 2'b00);
        end
        bus.req = 2'b00;
        run_frame(f_w, f_cs, f_gnt, f_ak, f_ok);
`ifdef PWM_SAFE_GAP_EN
        check("seqb_after_width", f_w, 460);
        check("seqb_after_state", f_cs, 2'b10);
`else
        check("seqb_after_width", f_w, 768);
        check("seqb_after_state", f_cs, 2'b11);
`endif
        check("seqb_after_grant", f_gnt, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_state_scheduler.md
# pwm_state_scheduler

Frame-based PWM command generator that drives the motor-state PWM line decoded by the downstream state reader. It arbitrates round-robin between `N_REQ` requesters, each asking for a 2-bit motor state (00 brake, 01 short, 10 open, 11 drive). It encodes the winning state as a pulse width inside a fixed 1024-clock frame and holds it for a minimum dwell before re-arbitrating.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `FRAME`, 1024: frame length in clocks; counter width is clog2(`FRAME`).
- `W_BRAKE`, 150: high width for state 00.
- `W_SHORT`, 358: high width for state 01.
- `W_OPEN`, 460: high width for state 10.
- `W_DRIVE`, 768: high width for state 11.
- `HOLD_FRAMES`, 4: minimum frames a granted state is transmitted (1..15).
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req`, in, `N_REQ`: request per requester; level, held until `ack`.
- `cmd`, in, 2*`N_REQ`: requested state; requester i on bits [2i+1:2i]; stable while `req[i]` is high.
- `ack`, out, `N_REQ`: one-clock pulse to the requester whose `cmd` was latched.
- `grant`, out, `N_REQ`: one-hot owner of the current state; 0 when no owner.
- `cur_state`, out, 2: state currently encoded on `pwm`.
- `pwm`, out, 1: registered PWM line to the state reader.
- `frame_start`, out, 1: registered pulse on the first clock of every frame.

## Operation
- Reset values: `pwm`=0, `ack`=0, `grant`=0, `cur_state`=00, `frame_start`=0, frame counter=0, dwell=0, round-robin pointer=0.
- Frame counter `cnt` runs 0..`FRAME`-1 and wraps. `pwm`=1 for exactly the width of `cur_state` consecutive clocks, starting on the clock where `frame_start`=1. It is 0 for the rest of the frame.
- FSM states:
  - RUN: normal frame output.
  - GAP: a single OPEN frame, used only with the macro.
- Decision point is the clock with `cnt`=`FRAME`-1:
  - If dwell>0: decrement dwell. `grant` and `cur_state` are unchanged.
  - If dwell=0 and any `req`: the winner is the first set bit searching upward from the pointer, wrapping. Latch its `cmd` as the next state and pulse `ack[winner]` on this clock. `grant` becomes one-hot winner, dwell loads `HOLD_FRAMES`-1, and the pointer becomes winner+1 mod `N_REQ`.
  - If dwell=0 and no `req`: `grant`=0 and `cur_state` repeats (last state persists).
- Simultaneous requests are resolved only by the pointer. A requester dropping `req` before `ack` is not served.
- `req` rising mid-frame is sampled only at the decision point. No partial frames are ever emitted.
- `reset` asserted mid-frame immediately forces all reset values. The first frame after release starts on the first clock with `reset` high and encodes BRAKE.
- Widths must satisfy 0 < W < `FRAME`. They are compared against `cnt` at full counter width.

## Timing
- Latency from `ack` to new width on `pwm` is 1 clock: the next frame's first clock. With a gap inserted, the latency is `FRAME`+1 clocks.
- `frame_start` and `pwm` are both registered and aligned. `ack`, `grant` and pointer update on the same edge.
- Minimum grant tenure is `HOLD_FRAMES` frames. A re-grant to the same requester is allowed if it is the only requester.
- Worst-case wait for any requester is `N_REQ`*`HOLD_FRAMES` frames.

## Configuration
- `PWM_SAFE_GAP_EN` defined:
  - Any decision that changes `cur_state` between 11 and 00/01 (either direction) first emits one GAP frame with `cur_state`=10 and width `W_OPEN`.
  - `ack` still pulses at the decision point. `grant` switches at the decision point.
  - The dwell count starts after the gap frame.
- `PWM_SAFE_GAP_EN` undefined: the GAP state is absent and the new state is applied directly on the next frame.

## Test plan
- Reset released, no req → `pwm` high 150 clocks per 1024, `cur_state`=00, `grant`=0, `frame_start` every 1024 clocks.
- `req`=01, `cmd[1:0]`=11 mid-frame → `ack[0]` at `cnt`=1023, next frame `pwm` high 768 clocks, `grant`=01 for ≥4 frames.
- `req`=11 held, `cmd`={01,10} → grants alternate 0,1,0 every 4 frames; widths alternate 460/358.
- Reset pulsed low at `cnt`=500 while driving 11 → `pwm`=0 at once; after release, 150-clock frame and pointer=0.
- With `PWM_SAFE_GAP_EN`, change 11→00 → one 460-clock frame, then 150-clock frames. Dwell covers 4 frames after the gap.
- Without `PWM_SAFE_GAP_EN`, same stimulus → 150-clock frame directly after the decision.
